// File: rtl/pll_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pll_clock_monitor
// Purpose  : Counts CLKMON edges per fixed CLKI window and derives a
//            frequency-qualified PLL lock with loss detection.
// Revision : 1.0 - initial release
// ============================================================================
module pll_clock_monitor #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int EXP_COUNT     = 512,
    parameter int TOL           = 4,
    parameter int LOCK_WINDOWS  = 4,
    parameter int CNT_W         = 16
) (
    input  logic             CLKI,
    input  logic             RESET,
    input  logic             CLKMON,
    input  logic             PLL_LOCK,
    input  logic             EN,
    output logic [CNT_W-1:0] MEAS_COUNT,
    output logic             MEAS_VALID,
    output logic             TOO_SLOW,
    output logic             TOO_FAST,
    output logic             LOCK_OUT,
    output logic             LOSS
);

    localparam int unsigned c_win_w  = $clog2(WINDOW_CYCLES);
    localparam int unsigned c_good_w = $clog2(LOCK_WINDOWS + 1);

    localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_lo        = CNT_W'(EXP_COUNT - TOL);
    localparam logic [CNT_W-1:0]    c_hi        = CNT_W'(EXP_COUNT + TOL);
    localparam logic [c_good_w-1:0] c_lock_last = c_good_w'(LOCK_WINDOWS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_CHECK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // CLKMON domain: binary edge counter with a registered Gray copy
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_mon_bin;
    logic [CNT_W-1:0] r_mon_gray;
    logic [CNT_W-1:0] w_mon_bin_nxt;

    assign w_mon_bin_nxt = r_mon_bin + CNT_W'(1);

    always_ff @(posedge CLKMON or posedge RESET) begin
        if (RESET) begin
            r_mon_bin  <= '0;
            r_mon_gray <= '0;
        end else begin
            r_mon_bin  <= w_mon_bin_nxt;
            r_mon_gray <= w_mon_bin_nxt ^ (w_mon_bin_nxt >> 1);
        end
    end

    // ------------------------------------------------------------------
    // CLKI domain: synchronizers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_gray_s1;
    logic [CNT_W-1:0] r_gray_s2;
    logic             r_lk_s1;
    logic             r_lk_s2;

    always_ff @(posedge CLKI or posedge RESET) begin
        if (RESET) begin
            r_gray_s1 <= '0;
            r_gray_s2 <= '0;
            r_lk_s1   <= 1'b0;
            r_lk_s2   <= 1'b0;
        end else begin
            r_gray_s1 <= r_mon_gray;
            r_gray_s2 <= r_gray_s1;
            r_lk_s1   <= PLL_LOCK;
            r_lk_s2   <= r_lk_s1;
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits at or above i
    logic [CNT_W-1:0] w_s;

    always_comb begin
        w_s = '0;
        for (int i = 0; i < CNT_W; i++) begin
            w_s[i] = ^(r_gray_s2 >> i);
        end
    end

    // ------------------------------------------------------------------
    // Window measurement and classification
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_win_w-1:0]  r_win_cnt;
    logic [c_win_w-1:0]  w_win_cnt_nxt;
    logic [c_good_w-1:0] r_good_cnt;
    logic [c_good_w-1:0] w_good_cnt_nxt;
    logic [CNT_W-1:0]    r_base;
    logic [CNT_W-1:0]    w_base_nxt;
    logic [CNT_W-1:0]    r_meas_count;
    logic [CNT_W-1:0]    w_meas_count_nxt;
    logic                r_meas_valid;
    logic                w_meas_valid_nxt;
    logic                r_too_slow;
    logic                w_too_slow_nxt;
    logic                r_too_fast;
    logic                w_too_fast_nxt;
    logic                r_lock_out;
    logic                w_lock_out_nxt;
    logic                r_loss;
    logic                w_loss_nxt;

    logic [CNT_W-1:0]    w_delta;
    logic                w_slow;
    logic                w_fast;
    logic                w_good;
    logic                w_tc;
    logic                w_run;

    // Modular subtraction keeps delta correct across counter wrap
    assign w_delta = w_s - r_base;
    assign w_slow  = (w_delta < c_lo);
    assign w_fast  = (w_delta > c_hi);
    assign w_good  = !w_slow && !w_fast;
    assign w_tc    = (r_state != S_IDLE) && (r_win_cnt == c_win_last);
    assign w_run   = EN && r_lk_s2;

    // ------------------------------------------------------------------
    // FSM: next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_win_cnt_nxt    = '0;
        w_good_cnt_nxt   = r_good_cnt;
        w_base_nxt       = r_base;
        w_meas_count_nxt = r_meas_count;
        w_meas_valid_nxt = 1'b0;
        w_too_slow_nxt   = r_too_slow;
        w_too_fast_nxt   = r_too_fast;
        w_lock_out_nxt   = r_lock_out;
        w_loss_nxt       = 1'b0;

        if (!w_run) begin
            // Abort wins over a coincident terminal count; the window is dropped
            w_state_nxt    = S_IDLE;
            w_good_cnt_nxt = '0;
            w_lock_out_nxt = 1'b0;
            w_loss_nxt     = (r_state == S_LOCKED);
        end else begin
            if (r_state != S_IDLE) begin
                w_win_cnt_nxt = w_tc ? '0 : (r_win_cnt + c_win_w'(1));
            end

            if (w_tc) begin
                w_base_nxt = w_s;
                if (r_state != S_PRIME) begin
                    w_meas_valid_nxt = 1'b1;
                    w_meas_count_nxt = w_delta;
                    w_too_slow_nxt   = w_slow;
                    w_too_fast_nxt   = w_fast;
                end
            end

            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_PRIME;
                end
                S_PRIME: begin
                    if (w_tc) begin
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_tc) begin
                        if (w_good) begin
                            w_good_cnt_nxt = r_good_cnt + c_good_w'(1);
                            if (r_good_cnt == c_lock_last) begin
                                w_state_nxt    = S_LOCKED;
                                w_lock_out_nxt = 1'b1;
                            end
                        end else begin
                            w_good_cnt_nxt = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    // good_cnt stays saturated while locked
                    if (w_tc && !w_good) begin
                        w_state_nxt    = S_CHECK;
                        w_good_cnt_nxt = '0;
                        w_lock_out_nxt = 1'b0;
                        w_loss_nxt     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLKI or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= '0;
            r_good_cnt   <= '0;
            r_base       <= '0;
            r_meas_count <= '0;
            r_meas_valid <= 1'b0;
            r_too_slow   <= 1'b0;
            r_too_fast   <= 1'b0;
            r_lock_out   <= 1'b0;
            r_loss       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_base       <= w_base_nxt;
            r_meas_count <= w_meas_count_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_too_slow   <= w_too_slow_nxt;
            r_too_fast   <= w_too_fast_nxt;
            r_lock_out   <= w_lock_out_nxt;
            r_loss       <= w_loss_nxt;
        end
    end

    assign MEAS_COUNT = r_meas_count;
    assign MEAS_VALID = r_meas_valid;
    assign TOO_SLOW   = r_too_slow;
    assign TOO_FAST   = r_too_fast;
    assign LOCK_OUT   = r_lock_out;
    assign LOSS       = r_loss;

endmodule
`default_nettype wire
